// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: fetch FSM states,
// PC source encodings, NZCV bit positions and the instruction word width.
package instr_fetch_unit_pkg;

   localparam int INSTR_W = 32;

   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } fetch_state_e;

   typedef enum logic [1:0] {
      PC_HOLD   = 2'b00,
      PC_INC    = 2'b01,
      PC_BRANCH = 2'b10,
      PC_REG    = 2'b11
   } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address from the fetch unit,
// ready/data back from memory.
interface instr_fetch_unit_if
   import instr_fetch_unit_pkg::*;
#(
   parameter int PC_W = 64
) ();

   logic               mem_rd;
   logic [PC_W-1:0]    mem_addr;
   logic               mem_ready;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: hold, PC+4, PC-relative branch on the
// word-scaled sign-extended k, or an absolute register target.
module instr_fetch_unit_pc_next_calc
   import instr_fetch_unit_pkg::*;
#(
   parameter int PC_W = 64
) (
   input  logic [PC_W-1:0]    pc,
   input  pc_sel_e            pc_sel,
   input  logic [INSTR_W-1:0] k,
   input  logic [PC_W-1:0]    reg_target,
   output logic [PC_W-1:0]    pc_next
);

   logic [PC_W-1:0] branch_off;

   // k counts instructions; widen with sign, then scale to bytes.
   assign branch_off = PC_W'($signed(k)) << 2;

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case can infer a latch.
   always_comb begin
      pc_next = pc;
      case (pc_sel)
         PC_INC:    pc_next = pc + PC_W'(4);
         PC_BRANCH: pc_next = pc + branch_off;
         PC_REG:    pc_next = reg_target;
         default:   pc_next = pc;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC, IR and NZCV status, runs the instruction memory read
// handshake. Define FETCH_TIMEOUT_EN to build the REQ watchdog (fetch_err).
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int              PC_W        = 64,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              TIMEOUT_CYC = 16
) (
   input  logic               clock,
   input  logic               reset,
   instr_fetch_unit_if.master mem,
   input  logic               fetch_start,
   input  logic               pc_load,
   input  logic [1:0]         pc_sel,
   input  logic [INSTR_W-1:0] k,
   input  logic [PC_W-1:0]    reg_target,
   input  logic               status_load,
   input  logic [3:0]         status_in,
   output logic [INSTR_W-1:0] IR,
   output logic               ir_valid,
   output logic [PC_W-1:0]    pc,
   output logic [3:0]         status,
   output logic               busy,
   output logic               fetch_err
);

   fetch_state_e       state, state_next;
   logic [PC_W-1:0]    pc_q, pc_next;
   logic [INSTR_W-1:0] ir_q;
   logic [3:0]         status_q;
   logic               ir_load;
   logic               timeout;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   instr_fetch_unit_pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
      .pc         (pc_q),
      .pc_sel     (pc_sel_e'(pc_sel)),
      .k          (k),
      .reg_target (reg_target),
      .pc_next    (pc_next)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      ir_load    = 1'b0;
      case (state)
         ST_IDLE: if (fetch_start) state_next = ST_REQ;
         ST_REQ: begin
            if (mem.mem_ready) begin
               state_next = ST_DONE;
               ir_load    = 1'b1;
            end else if (timeout) begin
               state_next = ST_IDLE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // PC is frozen while a request is outstanding so mem_addr stays stable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         status_q <= '0;
      end else begin
         if (pc_load && state != ST_REQ) pc_q <= pc_next;
         if (ir_load)                    ir_q <= mem.mem_rdata;
         if (status_load)                status_q <= status_in;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

   logic [WD_W-1:0] wd_cnt;
   logic            err_q;

   assign timeout = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= (state == ST_REQ) && !mem.mem_ready && timeout;
         if (state == ST_IDLE && fetch_start) wd_cnt <= '0;
         else if (state == ST_REQ)            wd_cnt <= wd_cnt + WD_W'(1);
      end
   end

   assign fetch_err = err_q;
`else
   assign timeout   = 1'b0;
   assign fetch_err = 1'b0;
`endif

   assign mem.mem_rd   = (state == ST_REQ);
   assign mem.mem_addr = pc_q;
   assign busy         = (state == ST_REQ);
   assign ir_valid     = (state == ST_DONE);
   assign IR           = ir_q;
   assign pc           = pc_q;
   assign status       = {status_q[NZCV_N], status_q[NZCV_Z], status_q[NZCV_C], status_q[NZCV_V]};

endmodule
